// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: NUM_MB transmit mailboxes in front of can_tx_path. The pending
// mailbox with the lowest identifier is launched; completion, lost arbitration and
// errors are folded back into per-mailbox pending/ok/fail status.
// Optional feature: define CAN_TX_SCHED_RETRY_LIMIT_EN to fail a mailbox after
// MAX_RETRY error retransmissions (otherwise retransmission is unlimited).
module can_tx_scheduler #(
  parameter int NUM_MB    = 3,
  parameter int MAX_RETRY = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mb_wr_en,
  input  logic [2:0]        mb_wr_idx,
  input  logic [10:0]       mb_wr_id,
  input  logic [3:0]        mb_wr_dlc,
  input  logic [63:0]       mb_wr_data,
  input  logic [NUM_MB-1:0] mb_abort,
  output logic              tx_start,
  output logic [10:0]       tx_id,
  output logic [3:0]        tx_dlc,
  output logic [63:0]       tx_data,
  input  logic              tx_done,
  input  logic              arbitration_lost,
  input  logic              tx_error,
  output logic [NUM_MB-1:0] mb_pending,
  output logic [NUM_MB-1:0] mb_ok,
  output logic [NUM_MB-1:0] mb_fail,
  output logic              wr_reject,
  output logic              active
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_LAUNCH, S_WAIT} state_t;

  state_t state_q, state_d;

  logic [NUM_MB-1:0] pending_q, pending_d;
  logic [10:0]       id_q   [NUM_MB];
  logic [10:0]       id_d   [NUM_MB];
  logic [3:0]        dlc_q  [NUM_MB];
  logic [3:0]        dlc_d  [NUM_MB];
  logic [63:0]       data_q [NUM_MB];
  logic [63:0]       data_d [NUM_MB];
  logic [2:0]        sel_q, sel_d;
  logic              abort_lat_q, abort_lat_d;
  logic [10:0]       tx_id_q, tx_id_d;
  logic [3:0]        tx_dlc_q, tx_dlc_d;
  logic [63:0]       tx_data_q, tx_data_d;
  logic [NUM_MB-1:0] ok_q, ok_d;
  logic [NUM_MB-1:0] fail_q, fail_d;
  logic              rej_q, rej_d;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
  logic [3:0]        retry_q [NUM_MB];
  logic [3:0]        retry_d [NUM_MB];
`else
  logic              unused_max_retry;
  assign unused_max_retry = (MAX_RETRY > 0);
`endif

  logic [NUM_MB-1:0] sel_oh, wr_oh;
  logic              cand_found;
  logic [2:0]        cand_idx;
  logic [10:0]       cand_id;
  logic [3:0]        cand_dlc;
  logic [63:0]       cand_data;
  logic              in_active, sel_abort, res_done, res_arb, res_err;

  // One-hot decode of the launched mailbox and the write target (out-of-range idx decodes to zero)
  always_comb begin
    sel_oh = '0;
    wr_oh  = '0;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      sel_oh[i] = (3'(i) == sel_q);
      wr_oh[i]  = (3'(i) == mb_wr_idx);
    end
  end

  // Lowest identifier among pending, non-aborting mailboxes; strict compare keeps the lower index on ties
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_id    = '1;
    cand_dlc   = '0;
    cand_data  = '0;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && !mb_abort[i] && (!cand_found || id_q[i] < cand_id)) begin
        cand_found = 1'b1;
        cand_idx   = 3'(i);
        cand_id    = id_q[i];
        cand_dlc   = dlc_q[i];
        cand_data  = data_q[i];
      end
    end
  end

  assign in_active = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign res_done  = (state_q == S_WAIT) && tx_done;
  assign res_arb   = (state_q == S_WAIT) && !tx_done && arbitration_lost;
  assign res_err   = (state_q == S_WAIT) && !tx_done && !arbitration_lost && tx_error;
  assign sel_abort = abort_lat_q || (|(mb_abort & sel_oh));

  // FSM next-state: idle -> select -> launch -> wait for resolution
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (enable && (|pending_q)) state_d = S_SELECT;
      S_SELECT: state_d = cand_found ? S_LAUNCH : S_IDLE;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (tx_done || arbitration_lost || tx_error) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Mailbox bookkeeping: aborts, frame selection, resolution and register writes
  always_comb begin
    pending_d   = pending_q;
    id_d        = id_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    sel_d       = sel_q;
    abort_lat_d = abort_lat_q;
    tx_id_d     = tx_id_q;
    tx_dlc_d    = tx_dlc_q;
    tx_data_d   = tx_data_q;
    ok_d        = '0;
    fail_d      = '0;
    rej_d       = 1'b0;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
    retry_d     = retry_q;
`endif

    // Abort of an idle pending mailbox takes effect at once; the in-flight one is only latched
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && mb_abort[i] && !(in_active && sel_oh[i])) begin
        pending_d[i] = 1'b0;
        fail_d[i]    = 1'b1;
      end
    end
    if (in_active && (|(mb_abort & sel_oh))) abort_lat_d = 1'b1;

    if (state_q == S_SELECT) begin
      abort_lat_d = 1'b0;
      if (cand_found) begin
        sel_d     = cand_idx;
        tx_id_d   = cand_id;
        tx_dlc_d  = cand_dlc;
        tx_data_d = cand_data;
      end
    end

    if (res_done) begin
      pending_d = pending_d & ~sel_oh;
      ok_d      = sel_oh;
    end else if ((res_arb || res_err) && sel_abort) begin
      pending_d = pending_d & ~sel_oh;
      fail_d    = fail_d | sel_oh;
    end else if (res_err) begin
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
      for (int unsigned i = 0; i < NUM_MB; i++) begin
        if (sel_oh[i]) begin
          if (retry_q[i] != 4'hF) retry_d[i] = retry_q[i] + 4'd1;
          if (int'(retry_q[i]) + 1 >= MAX_RETRY) begin
            pending_d[i] = 1'b0;
            fail_d[i]    = 1'b1;
          end
        end
      end
`endif
    end

    if (mb_wr_en) begin
      if (!(|wr_oh) || (|(wr_oh & pending_q))) begin
        rej_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_MB; i++) begin
          if (wr_oh[i]) begin
            pending_d[i] = 1'b1;
            id_d[i]      = mb_wr_id;
            dlc_d[i]     = mb_wr_dlc;
            data_d[i]    = mb_wr_data;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
            retry_d[i]   = '0;
`endif
          end
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Mailbox, launch and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      sel_q       <= '0;
      abort_lat_q <= 1'b0;
      tx_id_q     <= '0;
      tx_dlc_q    <= '0;
      tx_data_q   <= '0;
      ok_q        <= '0;
      fail_q      <= '0;
      rej_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_MB; i++) begin
        id_q[i]    <= '0;
        dlc_q[i]   <= '0;
        data_q[i]  <= '0;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
        retry_q[i] <= '0;
`endif
      end
    end else begin
      pending_q   <= pending_d;
      sel_q       <= sel_d;
      abort_lat_q <= abort_lat_d;
      tx_id_q     <= tx_id_d;
      tx_dlc_q    <= tx_dlc_d;
      tx_data_q   <= tx_data_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      rej_q       <= rej_d;
      id_q        <= id_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign tx_start   = (state_q == S_LAUNCH);
  assign active     = in_active;
  assign tx_id      = tx_id_q;
  assign tx_dlc     = tx_dlc_q;
  assign tx_data    = tx_data_q;
  assign mb_pending = pending_q;
  assign mb_ok      = ok_q;
  assign mb_fail    = fail_q;
  assign wr_reject  = rej_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: write-rule vector table, launch scoreboard checked on
// every tx_start, and hand sequences for latency, priority, arbitration loss,
// retries, aborts and reset.
module tb_can_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mb_wr_en;
  logic [2:0]  mb_wr_idx;
  logic [10:0] mb_wr_id;
  logic [3:0]  mb_wr_dlc;
  logic [63:0] mb_wr_data;
  logic [2:0]  mb_abort;
  logic        tx_start;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        tx_done;
  logic        arbitration_lost;
  logic        tx_error;
  logic [2:0]  mb_pending;
  logic [2:0]  mb_ok;
  logic [2:0]  mb_fail;
  logic        wr_reject;
  logic        active;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;
  frame_t exp_q[$];

  typedef struct {
    logic [2:0]  idx;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic        exp_rej;
    logic [2:0]  exp_pend;
  } wvec_t;
  wvec_t vec [6];

  can_tx_scheduler #(.NUM_MB(3), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mb_wr_en(mb_wr_en), .mb_wr_idx(mb_wr_idx), .mb_wr_id(mb_wr_id),
    .mb_wr_dlc(mb_wr_dlc), .mb_wr_data(mb_wr_data), .mb_abort(mb_abort),
    .tx_start(tx_start), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_done(tx_done), .arbitration_lost(arbitration_lost), .tx_error(tx_error),
    .mb_pending(mb_pending), .mb_ok(mb_ok), .mb_fail(mb_fail),
    .wr_reject(wr_reject), .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [2:0] idx, input logic [10:0] id);
    return {id, 50'h3_5A5A_5A5A_5A5A, idx};
  endfunction

  task automatic push_exp(input logic [2:0] idx, input logic [10:0] id, input logic [3:0] dlc);
    frame_t f;
    f.id = id; f.dlc = dlc; f.data = data_of(idx, id);
    exp_q.push_back(f);
  endtask

  // Every launch must match the oldest expected frame
  always @(negedge clk) begin : mon
    frame_t f;
    if (tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start actual=id 0x%0h required=no launch", tx_id);
      end else begin
        f = exp_q.pop_front();
        check("start_id", tx_id, f.id);
        check("start_dlc", tx_dlc, f.dlc);
        check("start_data", tx_data, f.data);
      end
    end
  end

  // Drive a write during the current cycle; returns one negedge later (after the sampling edge)
  task automatic write_mb(input logic [2:0] idx, input logic [10:0] id, input logic [3:0] dlc);
    mb_wr_en = 1'b1; mb_wr_idx = idx; mb_wr_id = id; mb_wr_dlc = dlc;
    mb_wr_data = data_of(idx, id);
    @(negedge clk);
    mb_wr_en = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s actual=no tx_start required=tx_start within 20 cycles", nm);
    end
  endtask

  // Called at the negedge of the LAUNCH cycle: resolve in the WAIT cycle, check status after
  task automatic resolve(input logic d, input logic a, input logic e,
                         input logic [2:0] eok, input logic [2:0] efail,
                         input logic [2:0] epend, input string nm);
    @(negedge clk);
    tx_done = d; arbitration_lost = a; tx_error = e;
    @(negedge clk);
    tx_done = 1'b0; arbitration_lost = 1'b0; tx_error = 1'b0;
    check({nm, "_ok"}, mb_ok, eok);
    check({nm, "_fail"}, mb_fail, efail);
    check({nm, "_pend"}, mb_pending, epend);
    check({nm, "_active"}, active, 1'b0);
  endtask

  initial begin
    int starts;
    vec[0] = '{3'd0, 11'h111, 4'd1, 1'b0, 3'b001};
    vec[1] = '{3'd0, 11'h222, 4'd7, 1'b1, 3'b001};
    vec[2] = '{3'd3, 11'h333, 4'd5, 1'b1, 3'b001};
    vec[3] = '{3'd7, 11'h001, 4'd6, 1'b1, 3'b001};
    vec[4] = '{3'd2, 11'h050, 4'd2, 1'b0, 3'b101};
    vec[5] = '{3'd1, 11'h050, 4'd3, 1'b0, 3'b111};

    rst = 1'b1; enable = 1'b0; mb_wr_en = 1'b0; mb_wr_idx = '0; mb_wr_id = '0;
    mb_wr_dlc = '0; mb_wr_data = '0; mb_abort = '0;
    tx_done = 1'b0; arbitration_lost = 1'b0; tx_error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_id", tx_id, 11'h0);
    check("rst_tx_dlc", tx_dlc, 4'h0);
    check("rst_tx_data", tx_data, 64'h0);
    check("rst_pending", mb_pending, 3'b000);
    check("rst_ok", mb_ok, 3'b000);
    check("rst_fail", mb_fail, 3'b000);
    check("rst_reject", wr_reject, 1'b0);
    check("rst_active", active, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Launch latency: pending after E, SELECT next cycle, tx_start the cycle after
    enable = 1'b1;
    push_exp(3'd0, 11'h123, 4'd2);
    write_mb(3'd0, 11'h123, 4'd2);
    check("lat_pend", mb_pending, 3'b001);
    check("lat_start_e0", tx_start, 1'b0);
    @(negedge clk);
    check("lat_start_e1", tx_start, 1'b0);
    check("lat_active_sel", active, 1'b0);
    @(negedge clk);
    check("lat_start_e2", tx_start, 1'b1);
    check("lat_active_launch", active, 1'b1);
    resolve(1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, "lat_done");
    @(negedge clk);
    check("lat_ok_pulse_end", mb_ok, 3'b000);

    // Write rules with launches held off by enable=0
    enable = 1'b0;
    for (int v = 0; v < 6; v++) begin
      write_mb(vec[v].idx, vec[v].id, vec[v].dlc);
      check($sformatf("wr%0d_reject", v), wr_reject, vec[v].exp_rej);
      check($sformatf("wr%0d_pend", v), mb_pending, vec[v].exp_pend);
    end
    @(negedge clk);
    check("wr_reject_clear", wr_reject, 1'b0);

    // Priority: mb1 (0x050, tie won by lower index), then mb2, then mb0 with its original data
    push_exp(3'd1, 11'h050, 4'd3);
    push_exp(3'd2, 11'h050, 4'd2);
    push_exp(3'd0, 11'h111, 4'd1);
    enable = 1'b1;
    wait_start("prio1_start");
    resolve(1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 3'b101, "prio1");
    wait_start("prio2_start");
    resolve(1'b1, 1'b0, 1'b0, 3'b100, 3'b000, 3'b001, "prio2");
    wait_start("prio3_start");
    resolve(1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, "prio3");

    // Lost arbitration with a higher-priority write arriving on the same edge
    push_exp(3'd0, 11'h300, 4'd3);
    write_mb(3'd0, 11'h300, 4'd3);
    wait_start("arb_first_start");
    @(negedge clk);
    arbitration_lost = 1'b1;
    mb_wr_en = 1'b1; mb_wr_idx = 3'd1; mb_wr_id = 11'h010; mb_wr_dlc = 4'd8;
    mb_wr_data = data_of(3'd1, 11'h010);
    push_exp(3'd1, 11'h010, 4'd8);
    push_exp(3'd0, 11'h300, 4'd3);
    @(negedge clk);
    arbitration_lost = 1'b0; mb_wr_en = 1'b0;
    check("arb_ok", mb_ok, 3'b000);
    check("arb_fail", mb_fail, 3'b000);
    check("arb_pend", mb_pending, 3'b011);
    wait_start("arb_hi_start");
    resolve(1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 3'b001, "arb_hi");
    wait_start("arb_relaunch_start");
    resolve(1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, "arb_relaunch");

    // Error retransmission against MAX_RETRY=3
    push_exp(3'd0, 11'h0AA, 4'd1);
    write_mb(3'd0, 11'h0AA, 4'd1);
    for (int k = 1; k <= 3; k++) begin
      wait_start($sformatf("retry%0d_start", k));
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
      if (k == 3) begin
        resolve(1'b0, 1'b0, 1'b1, 3'b000, 3'b001, 3'b000, "retry_limit");
      end else begin
        resolve(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b001, $sformatf("retry%0d", k));
        push_exp(3'd0, 11'h0AA, 4'd1);
      end
`else
      resolve(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b001, $sformatf("retry%0d", k));
      push_exp(3'd0, 11'h0AA, 4'd1);
`endif
    end
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
    starts = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx_start === 1'b1) starts++;
    end
    check("retry_no_fourth", starts, 0);
`else
    wait_start("retry_fourth_start");
    resolve(1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, "retry_fourth");
`endif

    // Abort of an idle pending mailbox
    enable = 1'b0;
    write_mb(3'd1, 11'h111, 4'd0);
    check("abort_idle_pend_before", mb_pending, 3'b010);
    mb_abort = 3'b010;
    @(negedge clk);
    mb_abort = 3'b000;
    check("abort_idle_fail", mb_fail, 3'b010);
    check("abort_idle_pend", mb_pending, 3'b000);
    check("abort_idle_ok", mb_ok, 3'b000);
    @(negedge clk);
    check("abort_idle_fail_end", mb_fail, 3'b000);

    // Abort of the in-flight mailbox, then completion: ok, no fail
    enable = 1'b1;
    push_exp(3'd0, 11'h0C0, 4'd4);
    write_mb(3'd0, 11'h0C0, 4'd4);
    wait_start("abort_wait_start");
    @(negedge clk);
    mb_abort = 3'b001;
    @(negedge clk);
    mb_abort = 3'b000;
    check("abort_wait_nofail", mb_fail, 3'b000);
    check("abort_wait_pend", mb_pending, 3'b001);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("abort_done_ok", mb_ok, 3'b001);
    check("abort_done_fail", mb_fail, 3'b000);
    check("abort_done_pend", mb_pending, 3'b000);

    // Latched abort of the in-flight mailbox, then error: fail, no relaunch
    push_exp(3'd2, 11'h0D0, 4'd5);
    write_mb(3'd2, 11'h0D0, 4'd5);
    wait_start("abort_err_start");
    @(negedge clk);
    mb_abort = 3'b100;
    @(negedge clk);
    mb_abort = 3'b000;
    tx_error = 1'b1;
    @(negedge clk);
    tx_error = 1'b0;
    check("abort_err_fail", mb_fail, 3'b100);
    check("abort_err_ok", mb_ok, 3'b000);
    check("abort_err_pend", mb_pending, 3'b000);

    // Reset while waiting on the TX path
    push_exp(3'd0, 11'h100, 4'd8);
    write_mb(3'd0, 11'h100, 4'd8);
    wait_start("rst_wait_start");
    @(negedge clk);
    mb_wr_en = 1'b1; mb_wr_idx = 3'd1; mb_wr_id = 11'h200; mb_wr_dlc = 4'd1;
    mb_wr_data = data_of(3'd1, 11'h200);
    @(negedge clk);
    mb_wr_en = 1'b0;
    check("rst_wait_pend_before", mb_pending, 3'b011);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_tx_start", tx_start, 1'b0);
    check("rstw_tx_id", tx_id, 11'h0);
    check("rstw_tx_dlc", tx_dlc, 4'h0);
    check("rstw_tx_data", tx_data, 64'h0);
    check("rstw_pending", mb_pending, 3'b000);
    check("rstw_active", active, 1'b0);
    check("rstw_ok_fail_rej", {mb_ok, mb_fail, wr_reject}, 7'b0);

    repeat (6) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
# can_tx_scheduler

Mailbox scheduler in front of `can_tx_path`. It holds NUM_MB transmit mailboxes written by the register interface and always launches the pending mailbox with the highest CAN priority (lowest identifier). It drives the TX path's start/frame inputs and resolves completion, lost arbitration and errors into per-mailbox status. It sits between the peripheral register bank and `can_tx_path`, and is the only block that asserts `tx_start`.

## Interface
Parameters:
- NUM_MB, 3: mailbox count, 2..8.
- MAX_RETRY, 8: error retransmissions per mailbox before failure. Used only with the retry limit compiled in.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits new launches. An in-flight frame always completes.
- mb_wr_en  in  1  mailbox load strobe.
- mb_wr_idx  in  3  target mailbox.
- mb_wr_id  in  11  identifier.
- mb_wr_dlc  in  4  DLC.
- mb_wr_data  in  64  payload.
- mb_abort  in  NUM_MB  per-mailbox abort request, level sampled each cycle.
- tx_start  out  1  one-cycle launch pulse to the TX path.
- tx_id  out  11  frame identifier to the TX path, registered.
- tx_dlc  out  4  frame DLC to the TX path, registered.
- tx_data  out  64  frame payload to the TX path, registered.
- tx_done  in  1  completion pulse from the TX path.
- arbitration_lost  in  1  lost-arbitration indication from the TX path.
- tx_error  in  1  error indication from the TX path.
- mb_pending  out  NUM_MB  mailbox holds an unsent frame.
- mb_ok  out  NUM_MB  one-cycle pulse per mailbox: frame sent.
- mb_fail  out  NUM_MB  one-cycle pulse per mailbox: aborted or retry limit reached.
- wr_reject  out  1  one-cycle pulse: write ignored.
- active  out  1  a frame is launched and unresolved.

## Operation
- Write rules:
  - A write to a non-pending mailbox stores the fields, sets mb_pending and clears that mailbox's retry count.
  - A write to a pending mailbox is ignored and pulses wr_reject.
  - A write with idx ≥ NUM_MB is ignored and pulses wr_reject.
- FSM states: IDLE, SELECT, LAUNCH, WAIT.
- IDLE → SELECT when enable=1 and any mb_pending bit is set.
- SELECT:
  - Choose the pending, non-aborting mailbox with the lowest 11-bit ID. Ties go to the lower index.
  - Register sel_idx, tx_id, tx_dlc and tx_data.
  - If there is no candidate, return to IDLE.
- LAUNCH: tx_start=1 for one cycle, then go to WAIT.
- WAIT resolves on the first of these inputs:
  - tx_done: clear pending[sel], pulse mb_ok[sel], go to IDLE.
  - arbitration_lost: mailbox stays pending, retry count unchanged, go to IDLE. The mailbox is re-arbitrated on the next pass, so a newly written higher-priority mailbox can win.
  - tx_error: increment retry[sel] (4-bit, saturating), keep pending, go to IDLE.
  - If tx_done and tx_error arrive in the same cycle, tx_done wins.
- Abort:
  - On a non-active pending mailbox: clear pending and pulse mb_fail next cycle.
  - On the active mailbox: the abort is latched. The frame is not cut. At resolution, tx_done gives mb_ok; any other outcome clears pending and gives mb_fail.
  - Abort of a non-pending mailbox is ignored.
- tx_id, tx_dlc and tx_data are held stable from LAUNCH until the next SELECT.
- enable=0 blocks the IDLE → SELECT transition only.

## Timing
- Write sampled at edge E: mb_pending is high after E. From IDLE, SELECT runs in cycle E+1 and tx_start is high in cycle E+2, giving a 2-cycle launch latency.
- Resolution input at edge R: status pulses in cycle R+1, and the state is IDLE after R. The earliest next tx_start is 2 cycles after R.
- Reset:
  - State is IDLE; all mailboxes are non-pending; retry counts are 0.
  - tx_start=0, tx_id=0, tx_dlc=0, tx_data=0.
  - mb_pending=0, mb_ok=0, mb_fail=0, wr_reject=0, active=0.
  - Reset mid-frame discards everything. `can_tx_path` shares the reset domain.
- active=1 in LAUNCH and WAIT.

## Configuration
- CAN_TX_SCHED_RETRY_LIMIT_EN defined:
  - A tx_error that brings retry[sel] to MAX_RETRY clears pending[sel] and pulses mb_fail[sel].
  - arbitration_lost never counts toward the limit.
- Undefined:
  - Retransmission is unlimited; mb_fail comes only from abort.
  - The retry counters are not built.

## Test plan
- Write mb0 with ID 0x123 and DLC 2 at edge E → tx_start in cycle E+2 with tx_id=0x123, tx_dlc=2. Then tx_done → mb_ok[0] pulse and mb_pending=0.
- Pending mb0 ID 0x200 and mb2 ID 0x050; also mb1 and mb2 both ID 0x050 → 0x050 from mb2 launches first; on the tie, mb1 wins; tx_done order matches priority.
- Launch mb0 ID 0x300, assert arbitration_lost, write mb1 ID 0x010 → the next tx_start carries 0x010; mb0 relaunches after it.
- With CAN_TX_SCHED_RETRY_LIMIT_EN and MAX_RETRY=3: tx_error on 3 launches → mb_fail[0] after the third, no fourth tx_start. Without the macro → a fourth tx_start.
- Abort mb1 while idle-pending → mb_fail[1] next cycle. Abort mb0 while in WAIT, then tx_done → mb_ok[0], no mb_fail.
- Write to pending mb0 → wr_reject pulse, data unchanged. Assert rst in WAIT → all outputs 0 the following cycle.
